esm_issue_buffer: RTL and testbench

ESM_ISSUE_BUFFER -- requirements
Module: esm_issue_buffer

---
 rtl/esm_issue_buffer.sv | 109 ++++++++++
 tb/tb_esm_issue_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/esm_issue_buffer.sv
// Out-of-order issue buffer: holds instructions until the dependency core clears them, then issues the lowest ready slot.
// Latency: one cycle from accept to issue register; backpressure: in_ready=!full, issue register holds while !issue_ready.
module esm_issue_buffer #(
    parameter int Instr_word_size = 32,
    parameter int bs              = 16,
    parameter int IW              = $clog2(bs)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [Instr_word_size-1:0] in_instr,
    output logic                       in_ready,
    output logic [IW-1:0]              alloc_index,
    input  logic [bs-1:0]              ready_positions,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [Instr_word_size-1:0] issue_instr,
    output logic [IW-1:0]              issue_index,
    output logic [IW:0]                occupancy,
    output logic                       full,
    output logic                       empty
);
    localparam logic [IW:0] OCC_FULL = (IW+1)'(bs);

    logic [Instr_word_size-1:0] r_mem [bs];
    logic [bs-1:0]              r_valid;
    logic [bs-1:0]              r_pending;
    logic                       r_issue_valid;
    logic [Instr_word_size-1:0] r_issue_instr;
    logic [IW-1:0]              r_issue_index;
    logic [IW:0]                r_occ;

    logic [IW-1:0] w_alloc_idx;
    logic [bs-1:0] w_elig;
    logic          w_elig_any;
    logic [IW-1:0] w_elig_idx;
    logic          w_full;
    logic          w_accept;
    logic          w_load;
    logic          w_hs;

    // Descending scan so the lowest-numbered match is the one that sticks.
    always_comb begin
        w_alloc_idx = '0;
        w_elig_idx  = '0;
        w_elig      = r_valid & ~r_pending & ready_positions;
        w_elig_any  = |w_elig;
        for (int i = bs - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_alloc_idx = IW'(i);
            if (w_elig[i])   w_elig_idx  = IW'(i);
        end
    end

    assign w_full   = (r_occ == OCC_FULL);
    assign w_accept = in_valid && !w_full;
    assign w_load   = !r_issue_valid || issue_ready;
    assign w_hs     = r_issue_valid && issue_ready;

    // Storage is never reset; a slot is only read once its valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_accept) r_mem[w_alloc_idx] <= in_instr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= '0;
            r_pending     <= '0;
            r_issue_valid <= 1'b0;
            r_issue_instr <= '0;
            r_issue_index <= '0;
            r_occ         <= '0;
        end else if (flush) begin
            r_valid       <= '0;
            r_pending     <= '0;
            r_issue_valid <= 1'b0;
            r_occ         <= '0;
        end else begin
            // The freed slot is pending, so it can never be the allocated or newly loaded slot.
            if (w_hs) begin
                r_valid[r_issue_index]   <= 1'b0;
                r_pending[r_issue_index] <= 1'b0;
            end
            if (w_accept) begin
                r_valid[w_alloc_idx]   <= 1'b1;
                r_pending[w_alloc_idx] <= 1'b0;
            end
            if (w_load) begin
                r_issue_valid <= w_elig_any;
                if (w_elig_any) begin
                    r_issue_instr         <= r_mem[w_elig_idx];
                    r_issue_index         <= w_elig_idx;
                    r_pending[w_elig_idx] <= 1'b1;
                end
            end
            if (w_accept && !w_hs)      r_occ <= r_occ + 1'b1;
            else if (w_hs && !w_accept) r_occ <= r_occ - 1'b1;
        end
    end

    assign in_ready    = !w_full;
    assign alloc_index = w_full ? '0 : w_alloc_idx;
    assign issue_valid = r_issue_valid;
    assign issue_instr = r_issue_instr;
    assign issue_index = r_issue_index;
    assign occupancy   = r_occ;
    assign full        = w_full;
    assign empty       = (r_occ == '0);
endmodule

// File: tb/tb_esm_issue_buffer.sv
// Directed bench for esm_issue_buffer: hand-computed expectations across accept, issue, stall, full, flush and reset.
module tb_esm_issue_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic [3:0]  alloc_index;
    logic [15:0] ready_positions = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [31:0] issue_instr;
    logic [3:0]  issue_index;
    logic [4:0]  occupancy;
    logic        full;
    logic        empty;

    int n_tests = 0;
    int n_fail  = 0;

    esm_issue_buffer #(.Instr_word_size(32), .bs(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .alloc_index(alloc_index), .ready_positions(ready_positions),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_instr(issue_instr), .issue_index(issue_index),
        .occupancy(occupancy), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_instr = base + 32'(i);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_ivld"}, issue_valid, 0);
        chk({pfx, "_iinstr"}, issue_instr, 0);
        chk({pfx, "_iidx"}, issue_index, 0);
        chk({pfx, "_occ"}, occupancy, 0);
        chk({pfx, "_empty"}, empty, 1);
        chk({pfx, "_full"}, full, 0);
        chk({pfx, "_inrdy"}, in_ready, 1);
        chk({pfx, "_alloc"}, alloc_index, 0);
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        chk_reset_state("rst0");

        // Single instruction: accept, issue one cycle later, handshake frees it.
        in_valid = 1'b1; in_instr = 32'hAAAA0001;
        ready_positions = 16'h0001; issue_ready = 1'b1;
        chk("single_alloc", alloc_index, 0);
        step();
        in_valid = 1'b0;
        chk("single_occ1", occupancy, 1);
        chk("single_novld", issue_valid, 0);
        step();
        chk("single_vld", issue_valid, 1);
        chk("single_instr", issue_instr, 32'hAAAA0001);
        chk("single_idx", issue_index, 0);
        step();
        chk("single_occ0", occupancy, 0);
        chk("single_empty", empty, 1);
        chk("single_done", issue_valid, 0);

        // Fill all slots with nothing ready, then release slots 2 and 15.
        ready_positions = 16'h0000;
        fill(16, 32'h1000_0000);
        chk("fill_occ", occupancy, 16);
        chk("fill_full", full, 1);
        chk("fill_inrdy", in_ready, 0);
        chk("fill_alloc", alloc_index, 0);
        ready_positions = 16'h8004;
        step();
        chk("rel_idx2", issue_index, 2);
        chk("rel_instr2", issue_instr, 32'h1000_0002);
        chk("rel_vld", issue_valid, 1);
        step();
        chk("rel_idx15", issue_index, 15);
        chk("rel_instr15", issue_instr, 32'h1000_000F);
        chk("rel_occ15", occupancy, 15);
        chk("rel_alloc2", alloc_index, 2);
        chk("rel_inrdy", in_ready, 1);

        // Stall: issue register holds while ready_positions toggles.
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ready_positions = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
            step();
            chk("stall_idx", issue_index, 15);
            chk("stall_instr", issue_instr, 32'h1000_000F);
            chk("stall_vld", issue_valid, 1);
        end
        ready_positions = 16'h0000;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush16_occ", occupancy, 0);
        chk("flush16_vld", issue_valid, 0);

        // Full boundary: handshake on slot 5 while full.
        fill(16, 32'h2000_0000);
        ready_positions = 16'h0020;
        step();
        chk("full5_idx", issue_index, 5);
        chk("full5_vld", issue_valid, 1);
        ready_positions = 16'h0000; issue_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hCCCC0005;
        chk("full5_inrdy_hs", in_ready, 0);
        step();
        in_valid = 1'b0;
        chk("full5_inrdy_next", in_ready, 1);
        chk("full5_alloc", alloc_index, 5);
        chk("full5_occ", occupancy, 15);
        chk("full5_vld_after", issue_valid, 0);
        ready_positions = 16'h0001;
        step();
        chk("sim_pre_idx", issue_index, 0);
        chk("sim_pre_occ", occupancy, 15);
        ready_positions = 16'h0000;
        in_valid = 1'b1; in_instr = 32'hCCCC0005;
        step();
        in_valid = 1'b0;
        chk("sim_occ", occupancy, 15);
        chk("sim_alloc0", alloc_index, 0);
        ready_positions = 16'h0020;
        step();
        chk("sim_store_idx", issue_index, 5);
        chk("sim_store_instr", issue_instr, 32'hCCCC0005);

        // Flush with 6 valid entries and one in the issue register; offered input dropped.
        ready_positions = 16'h0000; issue_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        fill(6, 32'h3000_0000);
        ready_positions = 16'h0001;
        step();
        chk("fl6_pre_vld", issue_valid, 1);
        chk("fl6_pre_occ", occupancy, 6);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'hDEAD0000;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl6_occ", occupancy, 0);
        chk("fl6_vld", issue_valid, 0);
        chk("fl6_empty", empty, 1);
        chk("fl6_alloc", alloc_index, 0);
        ready_positions = 16'hFFFF;
        step();
        chk("fl6_dropped", issue_valid, 0);

        // Reset mid-operation with an instruction offered.
        ready_positions = 16'h0000;
        fill(3, 32'h4000_0000);
        ready_positions = 16'h0002;
        step();
        chk("rst_pre_idx", issue_index, 1);
        rst = 1'b1; in_valid = 1'b1; in_instr = 32'hBEEF0000;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk_reset_state("rst1");
        ready_positions = 16'hFFFF; issue_ready = 1'b1;
        step();
        chk("rst1_notstored", issue_valid, 0);
        chk("rst1_occ_after", occupancy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
